// File: rtl/pingpong_frame_buffer.sv
// Ping-pong frame buffer: a producer fills one bank while the other drains one word per read tick.
`default_nettype none

module pingpong_frame_buffer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DIV    = 50
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              repeat_en,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  output logic              frame_done,
  output logic              underrun,
  output logic              bank_sel,
  output logic [ADDR_W:0]   fill_level
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TCW   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DATA_W-1:0] mem [0:2*DEPTH-1];

  logic [TCW-1:0]    tick_cnt;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] drain_cnt;
  logic              fill_full;
  logic              drain_active;

  logic              tick;
  logic              swap;
  logic              accept;
  logic              rd_fire;
  logic              rd_last;
  logic              rd_bank;
  logic [ADDR_W-1:0] rd_addr;

  assign tick    = (tick_cnt == TCW'(DIV - 1));
  assign swap    = fill_full && !drain_active && !flush;
  assign accept  = wr_valid && !fill_full && !flush;
  assign rd_fire = tick && !flush && (drain_active || swap);
  // In a swap cycle the bank just filled becomes the drain bank, starting at word 0.
  assign rd_addr = swap ? '0 : drain_cnt;
  assign rd_bank = swap ? bank_sel : ~bank_sel;
  assign rd_last = (rd_addr == ADDR_W'(DEPTH - 1));

  assign wr_ready   = !fill_full;
  assign fill_level = fill_full ? (ADDR_W+1)'(DEPTH) : {1'b0, fill_cnt};

  always_ff @(posedge clk) begin
    if (resetn && accept) begin
      mem[{bank_sel, fill_cnt}] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tick_cnt     <= '0;
      fill_cnt     <= '0;
      drain_cnt    <= '0;
      fill_full    <= 1'b0;
      drain_active <= 1'b0;
      bank_sel     <= 1'b0;
      y            <= '0;
      y_valid      <= 1'b0;
      frame_done   <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      y_valid    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      if (flush) begin
        tick_cnt     <= '0;
        fill_cnt     <= '0;
        drain_cnt    <= '0;
        fill_full    <= 1'b0;
        drain_active <= 1'b0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + TCW'(1);

        if (accept) begin
          if (fill_cnt == ADDR_W'(DEPTH - 1)) begin
            fill_full <= 1'b1;
            fill_cnt  <= '0;
          end else begin
            fill_cnt <= fill_cnt + ADDR_W'(1);
          end
        end

        if (swap) begin
          bank_sel     <= ~bank_sel;
          fill_full    <= 1'b0;
          drain_active <= 1'b1;
          drain_cnt    <= '0;
        end

        if (rd_fire) begin
          y         <= mem[{rd_bank, rd_addr}];
          y_valid   <= 1'b1;
          drain_cnt <= rd_addr + ADDR_W'(1);
          if (rd_last) begin
            frame_done <= 1'b1;
            // A waiting full frame always wins over replay; it swaps in next cycle.
            drain_active <= repeat_en && !(fill_full && !swap);
          end
        end else if (tick && !drain_active && !swap) begin
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pingpong_frame_buffer.sv
// Directed bench for pingpong_frame_buffer with a scoreboard of expected drain words.
`default_nettype none

module tb_pingpong_frame_buffer;

  localparam int DW   = 8;
  localparam int AW   = 2;
  localparam int DIVP = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic          repeat_en = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic [DW-1:0] y;
  logic          y_valid;
  logic          frame_done;
  logic          underrun;
  logic          bank_sel;
  logic [AW:0]   fill_level;

  pingpong_frame_buffer #(.DATA_W(DW), .ADDR_W(AW), .DIV(DIVP)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .repeat_en(repeat_en),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .y(y), .y_valid(y_valid), .frame_done(frame_done), .underrun(underrun),
    .bank_sel(bank_sel), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] d;
  } exp_t;

  exp_t q[$];
  exp_t e_m;
  int   checks = 0;
  int   errors = 0;
  int   under_cnt = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  bit   prev_in = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every y_valid.
  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      prev_in = 1'b0;
    end else begin
      if (underrun) under_cnt++;
      if (flush) prev_in = 1'b0;
      if (y_valid) begin
        if (q.size() == 0) begin
          check("y_valid_unexpected", y_valid, 0);
        end else begin
          e_m = q.pop_front();
          check("y_data", y, e_m.d);
          check("frame_done", frame_done, e_m.last);
        end
        if (prev_in) check("y_spacing", cyc - last_cyc, DIVP);
        last_cyc = cyc;
        prev_in  = !frame_done;
      end else begin
        check("frame_done_idle", frame_done, 0);
      end
    end
  end

  task automatic tick_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    flush = 1'b0;
    wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic write_word(input logic [DW-1:0] d, input bit push, input bit last);
    check("wr_ready_before_write", wr_ready, 1);
    wr_valid = 1'b1;
    wr_data  = d;
    if (push) q.push_back({last, d});
    tick_cyc();
    wr_valid = 1'b0;
  endtask

  task automatic write_frame(input logic [31:0] w, input bit push);
    for (int i = 0; i < 4; i++) write_word(w[31-8*i -: 8], push, i == 3);
  endtask

  task automatic wait_size(input int n, input string tag);
    int k;
    k = 0;
    while (q.size() != n && k < 200) begin
      tick_cyc();
      k++;
    end
    check(tag, q.size(), n);
  endtask

  task automatic expect_underrun_at(input int n);
    for (int k = 1; k < n; k++) begin
      tick_cyc();
      check("underrun_early", underrun, 0);
    end
    tick_cyc();
    check("underrun_due", underrun, 1);
  endtask

  initial begin
    int uc0;
    int k;

    // Reset state and idle underrun cadence.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick_cyc();
      if (i == 0) begin
        check("rst_bank_sel", bank_sel, 0);
        check("rst_fill_level", fill_level, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_frame_done", frame_done, 0);
      end
      check("idle_underrun", underrun, (i > 0 && i % 3 == 0) ? 1 : 0);
      check("idle_y", y, 0);
      check("idle_y_valid", y_valid, 0);
    end

    // Basic frame: fill, swap, drain, then underrun.
    write_frame(32'h11223344, 1'b1);
    check("full_wr_ready", wr_ready, 0);
    check("full_fill_level", fill_level, 4);
    tick_cyc();
    check("swap_bank_sel", bank_sel, 1);
    check("swap_wr_ready", wr_ready, 1);
    check("swap_fill_level", fill_level, 0);
    wait_size(0, "frame1_drained");
    check("post_frame_underrun", underrun, 0);
    expect_underrun_at(2);

    // Replay with repeat_en, then stop after the current frame.
    do_reset();
    repeat_en = 1'b1;
    write_frame(32'hA1A2A3A4, 1'b1);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) q.push_back({i == 3, 8'hA1 + 8'(i)});
    wait_size(4, "replay_two_frames");
    repeat_en = 1'b0;
    wait_size(0, "replay_third_frame");
    check("replay_end_underrun", underrun, 0);
    expect_underrun_at(2);

    // Second frame written during drain waits for frame_done, then follows without gap.
    do_reset();
    write_frame(32'h51525354, 1'b1);
    k = 0;
    while (bank_sel !== 1'b1 && k < 20) begin
      tick_cyc();
      k++;
    end
    check("a_swapped", bank_sel, 1);
    uc0 = under_cnt;
    write_frame(32'h61626364, 1'b1);
    check("b_full_wr_ready", wr_ready, 0);
    check("b_full_level", fill_level, 4);
    wait_size(4, "a_drained");
    check("b_swap_wr_ready", wr_ready, 1);
    check("b_swap_bank_sel", bank_sel, 0);
    wait_size(0, "b_drained");
    check("ab_no_underrun", under_cnt - uc0, 0);
    check("b_end_underrun", underrun, 0);
    expect_underrun_at(2);

    // Flush mid-fill, with a write that must be discarded.
    do_reset();
    write_word(8'h71, 1'b0, 1'b0);
    write_word(8'h72, 1'b0, 1'b0);
    check("midfill_level", fill_level, 2);
    flush = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'hEE;
    tick_cyc();
    flush = 1'b0;
    wr_valid = 1'b0;
    check("flush_fill_level", fill_level, 0);
    check("flush_wr_ready", wr_ready, 1);
    expect_underrun_at(3);

    // Flush mid-drain: y holds, drain stops, refill works.
    write_frame(32'h81828384, 1'b1);
    wait_size(2, "middrain_two_words");
    flush = 1'b1;
    tick_cyc();
    flush = 1'b0;
    q.delete();
    check("middrain_y_hold", y, 8'h82);
    check("middrain_y_valid", y_valid, 0);
    check("middrain_fill_level", fill_level, 0);
    check("middrain_wr_ready", wr_ready, 1);
    check("middrain_bank_sel", bank_sel, 1);
    expect_underrun_at(3);
    write_frame(32'h91929394, 1'b1);
    wait_size(0, "refill_drained");
    check("refill_end_underrun", underrun, 0);
    expect_underrun_at(2);

    // Reset during drain on a tick cycle.
    do_reset();
    write_frame(32'hC1C2C3C4, 1'b1);
    wait_size(3, "rst_drain_first");
    tick_cyc();
    resetn = 1'b0;
    tick_cyc();
    check("rstd_y", y, 0);
    check("rstd_y_valid", y_valid, 0);
    check("rstd_bank_sel", bank_sel, 0);
    check("rstd_frame_done", frame_done, 0);
    check("rstd_underrun", underrun, 0);
    check("rstd_fill_level", fill_level, 0);
    check("rstd_wr_ready", wr_ready, 1);
    resetn = 1'b1;
    q.delete();
    repeat (4) tick_cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pingpong_frame_buffer.md
PINGPONG_FRAME_BUFFER -- requirements
Module: pingpong_frame_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, word width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, bank address width (DEPTH = 2**ADDR_W words per bank).
REQ-003 The block SHALL have parameter DIV, default 50, read-tick period in clk cycles (DIV >= 1).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  synchronous abort of fill and drain.
REQ-007 repeat_en  input  1  replay drain bank when no new frame is ready.
REQ-008 wr_valid  input  1  producer word valid.
REQ-009 wr_data  input  DATA_W  producer word.
REQ-010 wr_ready  output  1  fill bank can accept a word.
REQ-011 y  output  DATA_W  registered drain word.
REQ-012 y_valid  output  1  one-cycle pulse, y updated.
REQ-013 frame_done  output  1  one-cycle pulse, last word of drain bank output.
REQ-014 underrun  output  1  one-cycle pulse, tick with no active drain.
REQ-015 bank_sel  output  1  current fill bank (0 or 1); drain bank is ~bank_sel.
REQ-016 fill_level  output  ADDR_W+1  words in fill bank (0..DEPTH).

Function
REQ-017 Two internal banks of DEPTH x DATA_W SHALL be held in the single clk domain; no derived clocks.
REQ-018 Tick counter SHALL count 0..DIV-1; tick is high in the cycle count == DIV-1, then count wraps to 0; DIV=1 gives tick every cycle.
REQ-019 wr_ready SHALL equal !fill_full; a word is accepted when wr_valid && wr_ready.
REQ-020 On accept, bank[bank_sel][fill_cnt] <= wr_data and fill_cnt increments; accept at fill_cnt == DEPTH-1 sets fill_full and wraps fill_cnt to 0; fill_level = fill_full ? DEPTH : fill_cnt.
REQ-021 Swap SHALL occur in any cycle with fill_full && !drain_active (registered values): bank_sel toggles, fill_full <= 0, drain_active <= 1, drain_cnt <= 0.
REQ-022 Tick with drain_active (or in a swap cycle) SHALL set y <= drain-bank word at drain_cnt (new drain bank, address 0, in a swap cycle) and pulse y_valid next cycle-edge; drain_cnt increments.
REQ-023 Tick at drain_cnt == DEPTH-1 SHALL pulse frame_done with y_valid; drain_cnt wraps to 0; drain_active stays 1 if repeat_en && !fill_full (replay), else clears.
REQ-024 When a finished drain and a full fill bank coincide, drain ends on the tick and swap follows next cycle; no replay.
REQ-025 Tick with !drain_active and no swap SHALL pulse underrun; y holds its value; y_valid stays 0.
REQ-026 Writes and reads SHALL never target the same bank; a write in a swap cycle is impossible because wr_ready is 0.
REQ-027 flush SHALL clear fill_cnt, fill_full, drain_active, drain_cnt, tick counter; bank_sel, y and bank contents hold; a write with flush is discarded.
REQ-028 All pulse outputs SHALL be low in every cycle not specified above.

Reset
REQ-029 resetn low at a clock edge SHALL set y=0, y_valid=0, frame_done=0, underrun=0, bank_sel=0, fill_level=0, wr_ready=1 on the following cycle, and clear tick counter, fill_cnt, drain_cnt, fill_full, drain_active.
REQ-030 Reset SHALL take priority over flush, write, swap and tick; bank contents need not be cleared.

Verification (DATA_W=8, ADDR_W=2, DEPTH=4, DIV=3)
REQ-031 Reset then write 0x11,0x22,0x33,0x44 back-to-back -> wr_ready low after 4th accept, swap next cycle, bank_sel=1, y = 0x11,0x22,0x33,0x44 on 4 consecutive ticks (3 cycles apart), frame_done with 0x44.
REQ-032 No writes after reset -> underrun pulses every 3rd cycle, y=0, y_valid never high.
REQ-033 Frame A drained with repeat_en=1 and no new frame -> frame A replays continuously with frame_done every 4 ticks; set repeat_en=0 -> drain stops after current frame, underrun follows.
REQ-034 Frame B fully written while frame A draining -> wr_ready low until A's frame_done, swap next cycle, first B word on next tick, no underrun if tick not in gap cycle.
REQ-035 Assert flush mid-fill (fill_level=2) and mid-drain -> fill_level=0, wr_ready=1, next tick pulses underrun; refill of 4 words resumes normal output.
REQ-036 Assert resetn low during drain with tick coincident -> y=0, y_valid=0, bank_sel=0 next cycle; no frame_done.
